// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters,
// latching the winner's operands and returning the settled result with a valid pulse.
module alu_arbiter #(
    parameter int SIZE   = 8,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic            req1,
    input  logic [SIZE-1:0] a0,
    input  logic [SIZE-1:0] b0,
    input  logic [SIZE-1:0] op0,
    input  logic [SIZE-1:0] a1,
    input  logic [SIZE-1:0] b1,
    input  logic [SIZE-1:0] op1,
    input  logic [SIZE-1:0] alu_res,
    output logic            gnt0,
    output logic            gnt1,
    output logic [SIZE-1:0] alu_a,
    output logic [SIZE-1:0] alu_b,
    output logic [SIZE-1:0] alu_op,
    output logic [SIZE-1:0] res,
    output logic            res_valid0,
    output logic            res_valid1,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    // SETTLE of 0 behaves like 1: the result is sampled on the first edge after the grant
    localparam logic [3:0] LOAD = SETTLE > 1 ? 4'(SETTLE - 1) : 4'd0;
    state_t     state;
    logic [3:0] cnt;
    logic       owner;
    logic       last_owner;
    logic       pick;
    always_comb pick = req1 & (~req0 | ~last_owner);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            res        <= '0;
            res_valid0 <= 1'b0;
            res_valid1 <= 1'b0;
            busy       <= 1'b0;
        end else begin
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            res_valid0 <= 1'b0;
            res_valid1 <= 1'b0;
            case (state)
                IDLE: if (req0 | req1) begin
                    gnt0       <= ~pick;
                    gnt1       <= pick;
                    alu_a      <= pick ? a1 : a0;
                    alu_b      <= pick ? b1 : b0;
                    alu_op     <= pick ? op1 : op0;
                    owner      <= pick;
                    last_owner <= pick;
                    cnt        <= LOAD;
                    busy       <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: if (cnt == 4'd0) begin
                    res        <= alu_res;
                    res_valid0 <= ~owner;
                    res_valid1 <= owner;
                    state      <= DONE;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two command requesters (the UART command interface and a second local command source) using a round-robin request/grant handshake. The winning requester's operands and opcode are latched into registers driving the ALU. After a programmable settle time the block samples the ALU result and returns it to the owner with a one-cycle valid pulse. It sits between the requesters and the ALU and is the only driver of the ALU inputs.

## Interface

- SIZE, 8, width of operands, opcode and result
- SETTLE, 1, cycles the ALU inputs are held before the result is sampled; legal 1..15, a value of 0 behaves as 1

Ports:

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request level from requester 0 / 1
- a0, b0, op0  in  SIZE each  operands and opcode of requester 0
- a1, b1, op1  in  SIZE each  operands and opcode of requester 1
- alu_res  in  SIZE  ALU result, combinational from alu_a/alu_b/alu_op
- gnt0 / gnt1  out  1  registered one-cycle grant pulse
- alu_a, alu_b, alu_op  out  SIZE each  registered ALU inputs
- res  out  SIZE  registered sampled result, held until next sample
- res_valid0 / res_valid1  out  1  one-cycle pulse: res belongs to requester 0 / 1
- busy  out  1  high while a transaction is in progress

## Operation

- States: IDLE, WAIT, DONE. Internal: 4-bit settle counter, 1-bit owner, 1-bit last_owner.
- IDLE, no request: stay; all pulses low, busy low.
- IDLE, exactly one reqN high: grant N.
- IDLE, both high: grant the requester not equal to last_owner.
- Grant edge: gntN<=1; alu_a/b/op<=aN/bN/opN; owner<=N; last_owner<=N; counter<=SETTLE-1; busy<=1; state<=WAIT.
- WAIT: gnt low. Counter decrements each cycle. When counter is 0, the edge does: res<=alu_res; res_valid[owner]<=1; state<=DONE.
- DONE: the valid pulse is visible for one cycle. Requests are not sampled. Next edge: valid<=0, busy<=0, state<=IDLE.
- Operand inputs are ignored outside the IDLE sampling edge. Changes after the grant do not affect alu_* or res.
- alu_a/b/op and res hold their last values after a transaction. They are not cleared.
- Requester rule: hold req and operands until gntN is seen. Deassert req no later than the cycle res_validN is high; a req still high in IDLE starts a new transaction.
- Reset (async, any state, including mid-transaction): state IDLE. All outputs 0: gnt*, res_valid*, busy, alu_a, alu_b, alu_op, res. last_owner=1, so the first tie goes to requester 0. An aborted transaction produces no res_valid.

## Timing

- Edge E0 samples req in IDLE. gntN and new alu_* are visible in the cycle after E0, for exactly one cycle.
- The result is sampled at edge E_SETTLE (SETTLE edges after E0). res_validN is high in the cycle after E_SETTLE.
- busy is high from after E0 through the DONE cycle.
- Earliest next sampling edge is E_SETTLE+2. Back-to-back period is SETTLE+2 cycles.
- With SETTLE=1, alu_res must be stable one cycle after alu_* change. With larger SETTLE, only its value at edge E_SETTLE matters.
- Simultaneous reset deassertion and req: the first edge after reset release samples req normally.

## Test plan

- SETTLE=1, adder ALU model, req0 with a0=8'h05, b0=8'h03 -> gnt0 pulses one cycle after E0; alu_a=8'h05; res=8'h08 with res_valid0 pulse at E0+1; res_valid1, gnt1 stay 0; busy high 2 cycles.
- req0 and req1 held high continuously after reset -> grants alternate 0,1,0,1. Grant spacing is SETTLE+2 cycles. Each res_valid matches its owner's result.
- Only req1 held high, a1 incremented after each res_valid1 -> every transaction is served with period SETTLE+2. Results track a1; no grant is ever given to requester 0.
- SETTLE=3, ALU model output forced 8'hAA until E0+2, then 8'hBB -> res=8'hBB sampled at E0+3; res_valid pulse at E0+3 only.
- reset asserted in WAIT -> all outputs 0 immediately, with no res_valid. After release, with both requesting, requester 0 wins.
- a0 changed from 8'h10 to 8'h7F the cycle after gnt0 -> alu_a stays 8'h10; res computed from 8'h10.
